ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter_pkg.sv | 10 +
 rtl/ram_arbiter_if.sv | 26 ++
 rtl/ram_arbiter_ram.sv | 23 ++
 rtl/ram_arbiter.sv | 117 +++++++++++
 tb/tb_ram_arbiter.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared constants for the two-requester RAM arbiter.
package ram_arbiter_pkg;

  localparam logic REQ_M0 = 1'b0;
  localparam logic REQ_M1 = 1'b1;

  // Wide enough for MAX_LOCK up to 15
  localparam int unsigned LOCK_CNT_W = 4;

endpackage

// File: rtl/ram_arbiter_if.sv
// One requester port of the RAM arbiter: access handshake plus read response.
interface ram_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
);

  logic                  valid;
  logic                  ready;
  logic                  write;
  logic                  lock;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output valid, write, lock, address, wdata,
    input  ready, rsp_valid, rdata
  );

  modport slave (
    input  valid, write, lock, address, wdata,
    output ready, rsp_valid, rdata
  );

endinterface

// File: rtl/ram_arbiter_ram.sv
// Single-port RAM: synchronous write, asynchronous read, no reset on contents.
module ram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_c
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_c = mem_q[addr_i];

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of a single-port RAM, with round-robin
// priority and a bounded lock that lets one requester hold ownership.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned MAX_LOCK   = 4
) (
  input  logic          clock,
  input  logic          reset,
  ram_arbiter_if.slave  m0,
  ram_arbiter_if.slave  m1
);

  logic                  prio_q, prio_d;
  logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic                  rsp0_valid_q, rsp0_valid_d;
  logic                  rsp1_valid_q, rsp1_valid_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;

  logic                  gnt0_c, gnt1_c, xfer_c, gnt_idx_c;
  logic                  gnt_write_c, gnt_lock_c, ram_we_c;
  logic [ADDR_WIDTH-1:0] ram_addr_c;
  logic [DATA_WIDTH-1:0] ram_wdata_c, ram_rdata_c;
  logic [LOCK_CNT_W-1:0] cnt_inc_c;

  // Arbitration and routing of the granted requester to the RAM
  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    if (!reset) begin
      if (m0.valid && m1.valid) begin
        gnt0_c = (prio_q == REQ_M0);
        gnt1_c = (prio_q == REQ_M1);
      end else begin
        gnt0_c = m0.valid;
        gnt1_c = m1.valid;
      end
    end
    xfer_c      = gnt0_c | gnt1_c;
    gnt_idx_c   = gnt1_c ? REQ_M1 : REQ_M0;
    gnt_write_c = gnt1_c ? m1.write   : m0.write;
    gnt_lock_c  = gnt1_c ? m1.lock    : m0.lock;
    ram_addr_c  = gnt1_c ? m1.address : m0.address;
    ram_wdata_c = gnt1_c ? m1.wdata   : m0.wdata;
    ram_we_c    = xfer_c && gnt_write_c;
  end

  ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk_i   (clock),
    .we_i    (ram_we_c),
    .addr_i  (ram_addr_c),
    .wdata_i (ram_wdata_c),
    .rdata_c (ram_rdata_c)
  );

  // Priority/lock update and read response capture
  always_comb begin
    prio_d       = prio_q;
    lock_cnt_d   = '0;
    rsp0_valid_d = 1'b0;
    rsp1_valid_d = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    // A lock run only continues for the requester that already owns priority
    cnt_inc_c    = (prio_q == gnt_idx_c) ? LOCK_CNT_W'(lock_cnt_q + LOCK_CNT_W'(1))
                                         : LOCK_CNT_W'(1);
    if (xfer_c) begin
      if (gnt_lock_c && (cnt_inc_c < LOCK_CNT_W'(MAX_LOCK))) begin
        prio_d     = gnt_idx_c;
        lock_cnt_d = cnt_inc_c;
      end else begin
        prio_d     = ~gnt_idx_c;
      end
      if (!gnt_write_c) begin
        if (gnt1_c) begin
          rsp1_valid_d = 1'b1;
          rdata1_d     = ram_rdata_c;
        end else begin
          rsp0_valid_d = 1'b1;
          rdata0_d     = ram_rdata_c;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prio_q       <= REQ_M0;
      lock_cnt_q   <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      prio_q       <= prio_d;
      lock_cnt_q   <= lock_cnt_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  assign m0.ready     = gnt0_c;
  assign m1.ready     = gnt1_c;
  assign m0.rsp_valid = rsp0_valid_q;
  assign m1.rsp_valid = rsp1_valid_q;
  assign m0.rdata     = rdata0_q;
  assign m1.rdata     = rdata1_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: reset, write/read-back, round robin,
// bounded locking and reset abort of a pending response.
module tb_ram_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   passes;
  logic [7:0] mem [16];

  ram_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) m0_if ();
  ram_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) m1_if ();

  ram_arbiter #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (4),
    .MAX_LOCK   (4)
  ) dut (
    .clock (clk),
    .reset (rst),
    .m0    (m0_if),
    .m1    (m1_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_m0(input logic v, input logic w, input logic l,
                        input logic [3:0] a, input logic [7:0] d);
    m0_if.valid = v; m0_if.write = w; m0_if.lock = l;
    m0_if.address = a; m0_if.wdata = d;
  endtask

  task automatic set_m1(input logic v, input logic w, input logic l,
                        input logic [3:0] a, input logic [7:0] d);
    m1_if.valid = v; m1_if.write = w; m1_if.lock = l;
    m1_if.address = a; m1_if.wdata = d;
  endtask

  initial begin
    logic exp0;
    checks = 0;
    passes = 0;
    rst = 1'b1;
    set_m0(1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
    set_m1(1'b1, 1'b0, 1'b0, 4'd0, 8'd0);

    // Reset state with both requesters asking
    @(negedge clk); #1;
    chk("rst_m0_ready", m0_if.ready, 0);
    chk("rst_m1_ready", m1_if.ready, 0);
    chk("rst_m0_rsp", m0_if.rsp_valid, 0);
    chk("rst_m1_rsp", m1_if.rsp_valid, 0);
    chk("rst_m0_rdata", m0_if.rdata, 0);
    chk("rst_m1_rdata", m1_if.rdata, 0);

    @(negedge clk);
    rst = 1'b0;
    set_m0(1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
    set_m1(1'b0, 1'b0, 1'b0, 4'd0, 8'd0);

    // Fill the RAM from m0 alone
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      mem[i] = {4'(i), 4'(15 - i)};
      set_m0(1'b1, 1'b1, 1'b0, 4'(i), mem[i]);
      #1;
      chk("fill_m0_ready", m0_if.ready, 1);
      chk("fill_m1_ready", m1_if.ready, 0);
      @(posedge clk); #1;
      if (i == 0) chk("write_no_rsp", m0_if.rsp_valid, 0);
    end

    // m0 writes A5 to addr 3, then m1 reads it back the next cycle
    @(negedge clk);
    set_m0(1'b1, 1'b1, 1'b0, 4'd3, 8'hA5);
    mem[3] = 8'hA5;
    #1 chk("wr3_m0_ready", m0_if.ready, 1);
    @(negedge clk);
    set_m0(1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
    set_m1(1'b1, 1'b0, 1'b0, 4'd3, 8'd0);
    #1 chk("rd3_m1_ready", m1_if.ready, 1);
    chk("rd3_no_early_rsp", m1_if.rsp_valid, 0);
    @(posedge clk); #1;
    chk("rd3_rsp", m1_if.rsp_valid, 1);
    chk("rd3_rdata", m1_if.rdata, 8'hA5);
    @(negedge clk);
    set_m1(1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
    @(posedge clk); #1;
    chk("rd3_pulse_end", m1_if.rsp_valid, 0);
    chk("rd3_rdata_held", m1_if.rdata, 8'hA5);

    // m1 alone reads the whole RAM back to back
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      set_m1(1'b1, 1'b0, 1'b0, 4'(i), 8'd0);
      #1 chk("seq_m1_ready", m1_if.ready, 1);
      @(posedge clk); #1;
      chk("seq_rsp", m1_if.rsp_valid, 1);
      chk("seq_rdata", m1_if.rdata, mem[i]);
    end
    @(negedge clk);
    set_m1(1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
    @(posedge clk); #1;
    chk("seq_end_rsp", m1_if.rsp_valid, 0);

    // Both valid, unlocked: strict alternation starting at m0
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      exp0 = (k % 2 == 0);
      set_m0(1'b1, 1'b0, 1'b0, 4'(k), 8'd0);
      set_m1(1'b1, 1'b0, 1'b0, 4'(k + 8), 8'd0);
      #1;
      chk("rr_m0_ready", m0_if.ready, exp0);
      chk("rr_m1_ready", m1_if.ready, !exp0);
      @(posedge clk); #1;
      chk("rr_m0_rsp", m0_if.rsp_valid, exp0);
      chk("rr_m1_rsp", m1_if.rsp_valid, !exp0);
      if (exp0) chk("rr_m0_rdata", m0_if.rdata, mem[k]);
      else      chk("rr_m1_rdata", m1_if.rdata, mem[k + 8]);
    end

    // Both valid, m0 locked: four m0 grants then one m1 grant, twice
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      exp0 = (k % 5 != 4);
      set_m0(1'b1, 1'b0, 1'b1, 4'd1, 8'd0);
      set_m1(1'b1, 1'b0, 1'b0, 4'd2, 8'd0);
      #1;
      chk("lock_m0_ready", m0_if.ready, exp0);
      chk("lock_m1_ready", m1_if.ready, !exp0);
    end
    @(negedge clk);
    set_m0(1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
    set_m1(1'b0, 1'b0, 1'b0, 4'd0, 8'd0);

    // m0 read (leaves priority at m1), then reset right after the transfer
    @(negedge clk);
    set_m0(1'b1, 1'b0, 1'b0, 4'd5, 8'd0);
    #1 chk("abort_m0_ready", m0_if.ready, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    set_m1(1'b1, 1'b0, 1'b0, 4'd3, 8'd0);
    #1;
    chk("abort_rsp", m0_if.rsp_valid, 0);
    chk("abort_rdata", m0_if.rdata, 0);
    chk("abort_m0_ready_low", m0_if.ready, 0);
    chk("abort_m1_ready_low", m1_if.ready, 0);
    @(posedge clk); #1;
    chk("abort_rsp_still_low", m0_if.rsp_valid, 0);

    // After release priority is back at m0 and RAM data survived
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_m0_ready", m0_if.ready, 1);
    chk("post_m1_ready", m1_if.ready, 0);
    @(posedge clk); #1;
    chk("post_m0_rsp", m0_if.rsp_valid, 1);
    chk("post_m0_rdata", m0_if.rdata, mem[5]);
    @(negedge clk);
    set_m0(1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
    #1 chk("post_m1_ready2", m1_if.ready, 1);
    @(posedge clk); #1;
    chk("post_m1_rsp", m1_if.rsp_valid, 1);
    chk("post_m1_rdata", m1_if.rdata, 8'hA5);
    @(negedge clk);
    set_m1(1'b0, 1'b0, 1'b0, 4'd0, 8'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
